// File: rtl/gray_to_binary.sv
// gray_to_binary: Gray-code to binary converter.
// Decodes Gray-coded words, such as async FIFO pointers that have crossed a
// clock domain, back to plain binary so they can be used in arithmetic.
// data_out_o is a zero-latency combinational decode of data_in_i. data_reg_o
// is a registered copy for consumers that need a flop boundary, and valid_o
// marks a word captured from a qualified input.
// DATA_WIDTH may be anything from 1 to 64.

module gray_to_binary #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_reg_o,
  output logic                  valid_o
);

  // Each binary bit is the running XOR of the Gray bits from the MSB down to
  // that bit. The MSB passes straight through. Any X or Z input bit is left
  // unmasked, so it shows up on that bit and on every lower bit.
  function automatic logic [DATA_WIDTH-1:0] gray_decode(
    input logic [DATA_WIDTH-1:0] gray
  );
    logic [DATA_WIDTH-1:0] bin;
    bin                 = '0;
    bin[DATA_WIDTH-1]   = gray[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Combinational decode. It uses no clock or reset, so it stays correct
  // while the registered path is held in reset or the clock is stopped.
  always_comb begin
    data_out_o = gray_decode(data_in_i);
  end

  // Registered copy. A qualified input is captured on every rising edge.
  // An unqualified edge holds the data and clears the valid flag. Reset
  // clears both outputs at once, without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      data_reg_o <= '0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        data_reg_o <= data_out_o;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_binary.sv
// tb_gray_to_binary: self-checking bench for gray_to_binary.
// Three instances are used: widths 11 and 4 for combinational sweeps and
// corner codes, and width 8 for the round trip and the registered path.
// Expected binary values come from an inverse lookup table. The table is
// filled by Gray-encoding every binary value (b ^ (b >> 1)) and recording b
// at that code. Leading zeros do not change the decode, so the one table
// serves every width up to 11.

module tb_gray_to_binary;

  logic        clk     = 1'b0;
  logic        clk_run = 1'b0;
  logic        arst_n  = 1'b0;

  logic [7:0]  din8, dout8, dreg8;
  logic        v_in8, v_out8;
  logic [10:0] din11, dout11, dreg11;
  logic        v_out11;
  logic [3:0]  din4, dout4, dreg4;
  logic        v_out4;

  int          check_count = 0;
  int          error_count = 0;

  logic [10:0] inv_gray [2048];

  logic [7:0]  exp_reg;
  logic        exp_valid;

  // Clock runs only when clk_run is set. The combinational sweeps run with
  // it idle.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  gray_to_binary #(.DATA_WIDTH(8)) u_dut8 (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .data_in_i  (din8),
    .data_out_o (dout8),
    .valid_i    (v_in8),
    .data_reg_o (dreg8),
    .valid_o    (v_out8)
  );

  gray_to_binary #(.DATA_WIDTH(11)) u_dut11 (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .data_in_i  (din11),
    .data_out_o (dout11),
    .valid_i    (1'b0),
    .data_reg_o (dreg11),
    .valid_o    (v_out11)
  );

  gray_to_binary #(.DATA_WIDTH(4)) u_dut4 (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .data_in_i  (din4),
    .data_out_o (dout4),
    .valid_i    (1'b0),
    .data_reg_o (dreg4),
    .valid_o    (v_out4)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] corner_in  [5];
    logic [3:0] corner_exp [5];

    for (int b = 0; b < 2048; b++) begin
      inv_gray[11'(b ^ (b >> 1))] = 11'(b);
    end

    corner_in[0] = 4'b0000; corner_exp[0] = 4'b0000;
    corner_in[1] = 4'b0001; corner_exp[1] = 4'b0001;
    corner_in[2] = 4'b0011; corner_exp[2] = 4'b0010;
    corner_in[3] = 4'b1000; corner_exp[3] = 4'b1111;
    corner_in[4] = 4'b1111; corner_exp[4] = 4'b1010;

    din8  = '0;
    din11 = '0;
    din4  = '0;
    v_in8 = 1'b0;
    #1;

    $display("[TB] reset state");
    checkOutput("reset_reg8",   64'(dreg8),  64'h0);
    checkOutput("reset_valid8", 64'(v_out8), 64'h0);

    // Combinational sweep with reset held low and the clock idle.
    $display("[TB] 11-bit combinational sweep");
    for (int n = 0; n < 2048; n++) begin
      din11 = 11'($urandom);
      #1;
      checkOutput("sweep11", 64'(dout11), 64'(inv_gray[din11]));
    end

    $display("[TB] 4-bit corner codes");
    for (int k = 0; k < 5; k++) begin
      din4 = corner_in[k];
      #1;
      checkOutput("corner4", 64'(dout4), 64'(corner_exp[k]));
    end

    $display("[TB] 8-bit round trip");
    for (int b = 0; b < 256; b++) begin
      din8 = 8'(b ^ (b >> 1));
      #1;
      checkOutput("roundtrip8", 64'(dout8), 64'(b));
    end
    checkOutput("reg8_idle_in_reset", 64'(dreg8), 64'h0);

    // Start the clock and release reset while the clock is low.
    clk_run = 1'b1;
    #2;
    arst_n = 1'b1;
    tick;
    tick;
    checkOutput("post_release_valid", 64'(v_out8), 64'h0);
    checkOutput("post_release_reg",   64'(dreg8),  64'h0);

    $display("[TB] single registered capture");
    din8  = 8'hC3;
    v_in8 = 1'b1;
    tick;
    checkOutput("cap_reg",       64'(dreg8),  64'h82);
    checkOutput("cap_reg_model", 64'(dreg8),  64'(inv_gray[{3'b0, 8'hC3}]));
    checkOutput("cap_valid",     64'(v_out8), 64'h1);
    v_in8 = 1'b0;
    din8  = 8'h5A;
    tick;
    checkOutput("hold_valid", 64'(v_out8), 64'h0);
    checkOutput("hold_reg",   64'(dreg8),  64'h82);

    $display("[TB] asynchronous reset");
    din8  = 8'($urandom);
    v_in8 = 1'b1;
    tick;
    checkOutput("pre_reset_valid", 64'(v_out8), 64'h1);
    checkOutput("pre_reset_reg",   64'(dreg8),  64'(inv_gray[{3'b0, din8}]));
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("async_reg",   64'(dreg8),  64'h0);
    checkOutput("async_valid", 64'(v_out8), 64'h0);
    din8 = 8'($urandom);
    #1;
    checkOutput("async_comb", 64'(dout8), 64'(inv_gray[{3'b0, din8}]));
    tick;
    checkOutput("reset_held_reg",   64'(dreg8),  64'h0);
    checkOutput("reset_held_valid", 64'(v_out8), 64'h0);
    v_in8  = 1'b0;
    arst_n = 1'b1;
    tick;
    checkOutput("discard_reg",   64'(dreg8),  64'h0);
    checkOutput("discard_valid", 64'(v_out8), 64'h0);

    $display("[TB] streaming Gray counter");
    for (int i = 0; i < 16; i++) begin
      din8  = 8'(i ^ (i >> 1));
      v_in8 = 1'b1;
      tick;
      checkOutput("stream_reg",   64'(dreg8),  64'(i));
      checkOutput("stream_valid", 64'(v_out8), 64'h1);
    end
    v_in8 = 1'b0;
    tick;
    checkOutput("stream_end_valid", 64'(v_out8), 64'h0);
    checkOutput("stream_end_reg",   64'(dreg8),  64'hF);

    $display("[TB] random registered traffic");
    exp_reg   = 8'hF;
    exp_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      v_in8 = 1'($urandom_range(0, 1));
      din8  = 8'($urandom);
      #1;
      checkOutput("rand_comb", 64'(dout8), 64'(inv_gray[{3'b0, din8}]));
      if (v_in8) exp_reg = inv_gray[{3'b0, din8}][7:0];
      exp_valid = v_in8;
      tick;
      checkOutput("rand_reg",   64'(dreg8),  64'(exp_reg));
      checkOutput("rand_valid", 64'(v_out8), 64'(exp_valid));
    end
    v_in8 = 1'b0;

    checkOutput("idle_reg11",   64'(dreg11),  64'h0);
    checkOutput("idle_valid11", 64'(v_out11), 64'h0);
    checkOutput("idle_reg4",    64'(dreg4),   64'h0);
    checkOutput("idle_valid4",  64'(v_out4),  64'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
